data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Single-port data memory that services the processor's data-side load/store requests (DataAddr, DataOut, ReadData, WriteData in; DataIn, DataDone out). It is the responder half of the data memory handshake: it accepts one request at a time, inserts a configurable number of wait states with DataDone low, then commits the access and returns read data with DataDone high. It sits between the processor core and on-chip RAM in the top-level system.

## Interface
- WORD_SIZE, 16, data word width in bits
- ADDR_BITS, 8, RAM index width; depth = 2**ADDR_BITS words
- WAIT_CYCLES, 2, fixed wait states per transaction (>= 0)

- Clock  input  1  single clock; all state changes on rising edge
- ResetN  input  1  asynchronous, active-low reset
- DataAddr  input  WORD_SIZE  word address of request
- DataOut  input  WORD_SIZE  write data from processor
- ReadData  input  1  load request
- WriteData  input  1  store request
- DataIn  output  WORD_SIZE  read data to processor, registered
- DataDone  output  1  high = no access pending / current access complete

## Operation
- Request = ReadData | WriteData, sampled at rising edge.
- States: IDLE, WAIT, DONE.
- IDLE: DataDone=1. On edge with request: latch address (low ADDR_BITS), write data, direction; go WAIT with counter=WAIT_CYCLES, or commit immediately and go DONE if WAIT_CYCLES=0.
- WAIT: DataDone=0. Counter decrements each edge; all request inputs ignored (processor holds the same request while stalled). On edge with counter==1: commit, go DONE.
- Commit: write -> RAM[addr] <= latched data, DataIn unchanged; read -> DataIn <= RAM[addr].
- DONE: DataDone=1, DataIn valid for a completed read. On edge with request: accept it as new transaction (same as IDLE); else go IDLE.
- ReadData and WriteData both high: treated as write; DataIn unchanged.
- Address bits above ADDR_BITS ignored (aliasing, wrap modulo depth).
- Read of never-written location returns undefined RAM content; RAM not reset.
- Reset (ResetN low, any state): state IDLE, counter 0, DataIn=0, DataDone=1. An uncommitted write in WAIT is discarded.

## Timing
- Request presented in cycle t, accepted at edge ending t.
- DataDone low cycles t+1 .. t+WAIT_CYCLES; high in t+WAIT_CYCLES+1 with DataIn valid (read).
- WAIT_CYCLES=0: DataDone never drops; read data valid in cycle t+1.
- Back-to-back: request present in DONE cycle is accepted at that edge; no idle bubble. Throughput one access per WAIT_CYCLES+1 cycles.
- DataIn held until the next read commit; DataDone and DataIn are register outputs (no combinational path from inputs).

## Configuration
- DMEM_RAND_WAIT_EN defined: each accepted transaction adds 0-3 extra wait cycles taken from bits [1:0] of an 8-bit Fibonacci LFSR (taps 8,6,5,4, reset seed 8'hA5), advanced once per accepted request; total wait = WAIT_CYCLES + extra, including when WAIT_CYCLES=0.
- Undefined: wait is exactly WAIT_CYCLES; no LFSR logic.

## Test plan
- Reset: hold ResetN low 3 cycles -> DataDone=1, DataIn=16'h0000, state IDLE.
- WAIT_CYCLES=2: store 16'h1234 to 16'h0005 held until done -> DataDone low exactly 2 cycles then high 1 cycle; subsequent load from 16'h0005 -> DataIn=16'h1234 in its DataDone-high cycle.
- Back-to-back: load of 16'h0005 asserted during store's DONE cycle -> accepted at that edge, DataDone low next cycle, no IDLE cycle between.
- ReadData=WriteData=1, addr 16'h0010, data 16'hBEEF -> write performed, DataIn unchanged; later load 16'h0010 -> 16'hBEEF.
- Aliasing (ADDR_BITS=8): store 16'hCAFE to 16'h0105 -> load 16'h0005 returns 16'hCAFE.
- Reset mid-WAIT of store 16'h5555 to 16'h0020 (after prior 16'h1111 there) -> after reset, load 16'h0020 returns 16'h1111; with DMEM_RAND_WAIT_EN, first transaction wait = WAIT_CYCLES + extra from seed 8'hA5, checked against bench LFSR model.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if
//    Data-side memory handshake between the processor core (master) and
//    the data memory responder (slave).
//
//    Signals:
//       DataAddr   master -> slave  word address of the request
//       DataOut    master -> slave  store data
//       ReadData   master -> slave  load request
//       WriteData  master -> slave  store request (wins over ReadData)
//       DataIn     slave -> master  load data, registered
//       DataDone   slave -> master  high = no access pending / access complete
interface data_mem_responder_if #(
   parameter int WORD_SIZE = 16
) ();

   logic [WORD_SIZE-1:0] DataAddr;
   logic [WORD_SIZE-1:0] DataOut;
   logic                 ReadData;
   logic                 WriteData;
   logic [WORD_SIZE-1:0] DataIn;
   logic                 DataDone;

   modport master (
      output DataAddr, DataOut, ReadData, WriteData,
      input  DataIn, DataDone
   );

   modport slave (
      input  DataAddr, DataOut, ReadData, WriteData,
      output DataIn, DataDone
   );

endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder
//    Single-port data RAM servicing the processor's load/store handshake.
//    One request is accepted at a time.  After acceptance DataDone stays
//    low for the wait states, then the access commits and DataDone
//    returns high with DataIn valid (for loads).  Both outputs come
//    straight from registers.
//
//    Parameters:
//       WORD_SIZE    data word width
//       ADDR_BITS    RAM index width, depth = 2**ADDR_BITS (upper address
//                    bits are ignored, so addresses alias modulo depth)
//       WAIT_CYCLES  fixed wait states per transaction (>= 0)
//
//    Ports:
//       Clock   rising-edge clock
//       ResetN  asynchronous active-low reset (RAM contents are kept)
//       bus     data_mem_responder_if.slave handshake
//
//    Build option:
//       DMEM_RAND_WAIT_EN  when defined, every accepted transaction adds
//                          0-3 extra wait states taken from bits [1:0] of
//                          an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed
//                          8'hA5) that advances once per accepted request.
module data_mem_responder #(
   parameter int WORD_SIZE   = 16,
   parameter int ADDR_BITS   = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                 Clock,
   input  logic                 ResetN,
   data_mem_responder_if.slave  bus
);

   localparam int DEPTH = 2 ** ADDR_BITS;
   // Counter must hold WAIT_CYCLES plus up to 3 random extra states.
   localparam int CNT_W = $clog2(WAIT_CYCLES + 4);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                 state_reg, state_next;
   logic [CNT_W-1:0]       count_reg, count_next;
   logic [ADDR_BITS-1:0]   addr_reg, addr_next;
   logic [WORD_SIZE-1:0]   wdata_reg, wdata_next;
   logic                   write_reg, write_next;
   logic                   done_reg, done_next;
   logic [WORD_SIZE-1:0]   data_in_reg;

   logic [WORD_SIZE-1:0]   mem [DEPTH];

   logic                   request;
   logic                   accept;
   logic [CNT_W-1:0]       extra_wait;
   logic [CNT_W-1:0]       req_wait;
   logic                   commit;
   logic                   commit_write;
   logic [ADDR_BITS-1:0]   commit_addr;
   logic [WORD_SIZE-1:0]   commit_data;

   assign request  = bus.ReadData | bus.WriteData;
   // While stalled the processor keeps its request up; it must not be
   // taken as a second transaction.
   assign accept   = request && (state_reg != ST_WAIT);
   assign req_wait = CNT_W'(WAIT_CYCLES) + extra_wait;

`ifdef DMEM_RAND_WAIT_EN
   logic [7:0] lfsr_reg, lfsr_next;

   always_comb begin
      lfsr_next = lfsr_reg;
      if (accept) begin
         lfsr_next = {lfsr_reg[6:0],
                      lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
      end
   end

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         lfsr_reg <= 8'hA5;
      end else begin
         lfsr_reg <= lfsr_next;
      end
   end

   // The value present when the request is accepted sets its extra wait.
   assign extra_wait = CNT_W'(lfsr_reg[1:0]);
`else
   assign extra_wait = '0;
`endif

   // ---------------------------------------------------------------
   // State register (plus latched request and registered outputs)
   // ---------------------------------------------------------------
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state_reg   <= ST_IDLE;
         count_reg   <= '0;
         addr_reg    <= '0;
         wdata_reg   <= '0;
         write_reg   <= 1'b0;
         done_reg    <= 1'b1;
         data_in_reg <= '0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         addr_reg  <= addr_next;
         wdata_reg <= wdata_next;
         write_reg <= write_next;
         done_reg  <= done_next;
         if (commit && !commit_write) begin
            data_in_reg <= mem[commit_addr];
         end
      end
   end

   // RAM array: no reset.  A write still waiting when reset hits never
   // reaches commit, so it is dropped.
   always_ff @(posedge Clock) begin
      if (commit && commit_write && ResetN) begin
         mem[commit_addr] <= commit_data;
      end
   end

   // ---------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      case (state_reg)
         ST_IDLE, ST_DONE: begin
            if (request) begin
               if (req_wait == '0) begin
                  state_next = ST_DONE;
                  count_next = '0;
               end else begin
                  state_next = ST_WAIT;
                  count_next = req_wait;
               end
            end else begin
               state_next = ST_IDLE;
               count_next = '0;
            end
         end
         ST_WAIT: begin
            if (count_reg <= CNT_W'(1)) begin
               state_next = ST_DONE;
               count_next = '0;
            end else begin
               count_next = count_reg - CNT_W'(1);
            end
         end
         default: begin
            state_next = ST_IDLE;
            count_next = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Output / datapath control logic
   // ---------------------------------------------------------------
   always_comb begin
      addr_next    = addr_reg;
      wdata_next   = wdata_reg;
      write_next   = write_reg;
      commit       = 1'b0;
      commit_write = write_reg;
      commit_addr  = addr_reg;
      commit_data  = wdata_reg;

      if (accept) begin
         addr_next  = bus.DataAddr[ADDR_BITS-1:0];
         wdata_next = bus.DataOut;
         // Simultaneous load and store is serviced as a store.
         write_next = bus.WriteData;
      end

      if (state_reg == ST_WAIT) begin
         commit = (count_reg <= CNT_W'(1));
      end else if (accept && (req_wait == '0)) begin
         // Zero-wait access commits straight from the bus inputs.
         commit       = 1'b1;
         commit_write = bus.WriteData;
         commit_addr  = bus.DataAddr[ADDR_BITS-1:0];
         commit_data  = bus.DataOut;
      end

      // Registered so DataDone has no combinational path from the inputs.
      done_next = (state_next != ST_WAIT);
   end

   assign bus.DataIn   = data_in_reg;
   assign bus.DataDone = done_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//    Directed-vector bench for data_mem_responder.  A transaction-level
//    model (memory array + per-cycle expected DataDone/DataIn timeline)
//    is advanced by the driver; one compare process checks the DUT on
//    every falling edge, plus literal pins on key results.
module tb_data_mem_responder;

   localparam int WORD_SIZE   = 16;
   localparam int ADDR_BITS   = 8;
   localparam int WAIT_CYCLES = 2;

   logic Clock;
   logic ResetN;

   data_mem_responder_if #(.WORD_SIZE(WORD_SIZE)) bus ();

   data_mem_responder #(
      .WORD_SIZE   (WORD_SIZE),
      .ADDR_BITS   (ADDR_BITS),
      .WAIT_CYCLES (WAIT_CYCLES)
   ) dut (
      .Clock  (Clock),
      .ResetN (ResetN),
      .bus    (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Model state
   logic [WORD_SIZE-1:0] model_mem [2**ADDR_BITS];
   logic                 exp_done;
   logic [WORD_SIZE-1:0] exp_data;
   bit                   chk_en;
`ifdef DMEM_RAND_WAIT_EN
   logic [7:0]           tb_lfsr;
`endif

   // Literal pins
   bit                   pin_data_en;
   logic [WORD_SIZE-1:0] pin_data_val;
   bit                   pin_low_en;
   int                   pin_low_val;
   string                pin_name;

   int n_tests;
   int n_fail;
   int cyc;
   int low_run;
   int last_low_run;

   always @(posedge Clock) cyc <= cyc + 1;

   // Single compare process
   always @(negedge Clock) begin
      if (chk_en) begin
         n_tests++;
         if (bus.DataDone !== exp_done) begin
            n_fail++;
            $display("FAIL done_cycle cyc=%0d got=%b expected=%b", cyc, bus.DataDone, exp_done);
         end
         n_tests++;
         if (bus.DataIn !== exp_data) begin
            n_fail++;
            $display("FAIL datain_cycle cyc=%0d got=%h expected=%h", cyc, bus.DataIn, exp_data);
         end
         if (bus.DataDone === 1'b1) begin
            if (low_run != 0) last_low_run = low_run;
            low_run = 0;
         end else begin
            low_run++;
         end
         if (pin_data_en) begin
            n_tests++;
            if (bus.DataIn !== pin_data_val) begin
               n_fail++;
               $display("FAIL %s cyc=%0d got=%h expected=%h", pin_name, cyc, bus.DataIn, pin_data_val);
            end
         end
         if (pin_low_en) begin
            n_tests++;
            if (last_low_run != pin_low_val) begin
               n_fail++;
               $display("FAIL %s cyc=%0d low_cycles got=%0d expected=%0d", pin_name, cyc, last_low_run, pin_low_val);
            end
         end
      end
   end

   // Advance one cycle; inputs/expectations are then set 1ns after the edge.
   task automatic step();
      @(posedge Clock);
      #1;
      pin_data_en = 1'b0;
      pin_low_en  = 1'b0;
   endtask

   task automatic idle(input int n);
      bus.ReadData  = 1'b0;
      bus.WriteData = 1'b0;
      for (int i = 0; i < n; i++) begin
         step();
         exp_done = 1'b1;
      end
   endtask

   // Present a request in the current cycle, hold it through the wait
   // states, and return 1ns into its DataDone-high cycle with the request
   // still asserted (caller either chains another txn or idles).
   task automatic txn(input bit rd, input bit wr,
                      input logic [WORD_SIZE-1:0] a, input logic [WORD_SIZE-1:0] d);
      int w;
      bus.ReadData  = rd;
      bus.WriteData = wr;
      bus.DataAddr  = a;
      bus.DataOut   = d;
      w = WAIT_CYCLES;
`ifdef DMEM_RAND_WAIT_EN
      w += int'(tb_lfsr[1:0]);
      tb_lfsr = {tb_lfsr[6:0], tb_lfsr[7] ^ tb_lfsr[5] ^ tb_lfsr[4] ^ tb_lfsr[3]};
`endif
      $display("[TB] txn cyc=%0d rd=%0b wr=%0b addr=%h data=%h wait=%0d", cyc, rd, wr, a, d, w);
      for (int k = 0; k < w; k++) begin
         step();
         exp_done = 1'b0;
      end
      step();
      exp_done = 1'b1;
      if (wr) model_mem[a[ADDR_BITS-1:0]] = d;
      else if (rd) exp_data = model_mem[a[ADDR_BITS-1:0]];
   endtask

   task automatic pin_data(input string name, input logic [WORD_SIZE-1:0] v);
      pin_name     = name;
      pin_data_val = v;
      pin_data_en  = 1'b1;
   endtask

   task automatic pin_low(input string name, input int v);
      pin_name    = name;
      pin_low_val = v;
      pin_low_en  = 1'b1;
   endtask

   int first_wait;

   initial begin
      n_tests = 0; n_fail = 0; cyc = 0; low_run = 0; last_low_run = 0;
      chk_en = 1'b0; pin_data_en = 1'b0; pin_low_en = 1'b0; pin_name = "";
      pin_data_val = '0; pin_low_val = 0;
      exp_done = 1'b1; exp_data = '0;
`ifdef DMEM_RAND_WAIT_EN
      tb_lfsr = 8'hA5;
      first_wait = WAIT_CYCLES + 1;   // seed 8'hA5 -> bits[1:0] = 2'b01
`else
      first_wait = 2;
`endif
      ResetN = 1'b0;
      bus.ReadData = 1'b0; bus.WriteData = 1'b0;
      bus.DataAddr = '0;   bus.DataOut = '0;

      // Reset held low three cycles
      repeat (3) @(posedge Clock);
      #1;
      chk_en = 1'b1;
      pin_data("reset_datain", 16'h0000);
      step();
      ResetN = 1'b1;
      exp_done = 1'b1;
      idle(2);

      // Store then back-to-back load
      txn(1'b0, 1'b1, 16'h0005, 16'h1234);
      pin_low("store_wait_len", first_wait);
      txn(1'b1, 1'b0, 16'h0005, 16'h0000);
      pin_data("load_after_store", 16'h1234);
      idle(1);

      // Load+store together is a store; DataIn keeps the previous load
      txn(1'b1, 1'b1, 16'h0010, 16'hBEEF);
      pin_data("rdwr_datain_kept", 16'h1234);
      idle(1);
      txn(1'b1, 1'b0, 16'h0010, 16'h0000);
      pin_data("load_after_rdwr", 16'hBEEF);
      idle(1);

      // Address aliasing
      txn(1'b0, 1'b1, 16'h0105, 16'hCAFE);
      idle(1);
      txn(1'b1, 1'b0, 16'h0005, 16'h0000);
      pin_data("alias_load", 16'hCAFE);
      idle(1);

      // Reset in the middle of a store
      txn(1'b0, 1'b1, 16'h0020, 16'h1111);
      idle(1);
      bus.ReadData = 1'b0; bus.WriteData = 1'b1;
      bus.DataAddr = 16'h0020; bus.DataOut = 16'h5555;
      $display("[TB] txn cyc=%0d rd=0 wr=1 addr=0020 data=5555 interrupted by reset", cyc);
      step();
      exp_done = 1'b0;
      ResetN = 1'b0;
      bus.WriteData = 1'b0;
      exp_done = 1'b1;
      exp_data = '0;
      step();
      step();
      ResetN = 1'b1;
`ifdef DMEM_RAND_WAIT_EN
      tb_lfsr = 8'hA5;
`endif
      idle(1);
      txn(1'b1, 1'b0, 16'h0020, 16'h0000);
      pin_data("reset_discards_store", 16'h1111);
      pin_low("post_reset_wait_len", first_wait);

      // Chained accesses with no idle cycles
      txn(1'b0, 1'b1, 16'h00FF, 16'hA5A5);
      txn(1'b1, 1'b0, 16'h00FF, 16'h0000);
      pin_data("chain_load_ff", 16'hA5A5);
      txn(1'b1, 1'b0, 16'h0110, 16'h0000);
      pin_data("chain_load_alias10", 16'hBEEF);
      idle(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
